// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One shared WIDTH-bit adder, one quotient/product bit per cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dreg;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               sgn_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               take;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    // operand conditioning: signed ops iterate on magnitudes
    always_comb begin
        sgn_op = ~op[0];
        abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
        abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
    end

    // shared adder: add multiplicand, or subtract divisor from shifted rem
    always_comb begin
        rem_sh = acc[2*WIDTH-2:WIDTH-1];
        add_x  = is_div ? rem_sh : acc[2*WIDTH-1:WIDTH];
        add_y  = is_div ? ~dreg : dreg;
        {cout, sum} = {1'b0, add_x} + {1'b0, add_y}
                    + {{WIDTH{1'b0}}, is_div};
        // a set bit shifted out of the remainder means it already exceeds
        // any divisor, so the subtraction must be kept
        take   = cout | acc[2*WIDTH-1];
    end

    // final sign fix-up; a zero divisor leaves an all-ones quotient
    always_comb begin
        prod    = neg_res ? -acc : acc;
        quo_fix = div_zero ? '1
                : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // sequencer, datapath registers and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            dreg     <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        is_div   <= op[1];
                        neg_res  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= sgn_op & op[1] & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        cnt      <= '0;
                        if (op[1]) begin
                            dreg <= abs_b;
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            dreg <= abs_a;
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                        end
                        state <= CALC;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            if (take)
                                acc <= {sum, acc[WIDTH-2:0], 1'b1};
                            else
                                acc <= {rem_sh, acc[WIDTH-2:0], 1'b0};
                        end else begin
                            if (acc[0])
                                acc <= {cout, sum, acc[WIDTH-1:1]};
                            else
                                acc <= {1'b0, acc[2*WIDTH-1:1]};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST)
                            state <= SIGN;
                    end
                end
                SIGN: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
